// File: rtl/duck_pkg.sv
// Shared types and constants for the duck spawn scheduler: FSM encoding,
// lane width and the 4-bit LFSR feedback taps.
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam int LANE_W = 3;

  // Taps on bits 3 and 2 give x^4+x^3+1 (maximal length, period 15).
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic [3:0] lfsr4_next(input logic [3:0] q);
    return {q[2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr4_core.sv
// Free-running 4-bit Fibonacci LFSR. A zero seed would lock up the register,
// so it is replaced by 4'hF.
module lfsr4_core
  import duck_pkg::*;
#(
  parameter logic [3:0] SEED = 4'hF
) (
  input  logic       clk0,
  input  logic       rst,
  output logic [3:0] q_o
);

  localparam logic [3:0] SEED_EFF = (SEED == 4'h0) ? 4'hF : SEED;

  logic [3:0] q_q;

  always_ff @(posedge clk0) begin
    if (rst) begin
      q_q <= SEED_EFF;
    end else begin
      q_q <= lfsr4_next(q_q);
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/duck_spawn_scheduler.sv
// Round-robin spawn arbiter for the duck slots: picks a requesting slot, waits a
// random number of frame ticks, then pulses a one-hot grant with lane/direction.
module duck_spawn_scheduler
  import duck_pkg::*;
#(
  parameter int         NUM_DUCKS  = 2,
  parameter int         DELAY_BASE = 8,
  parameter logic [3:0] LFSR_SEED  = 4'hF
) (
  input  logic                 clk0,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [NUM_DUCKS-1:0] spawn_req,
  output logic [NUM_DUCKS-1:0] spawn_grant,
  output logic [LANE_W-1:0]    spawn_lane,
  output logic                 spawn_dir,
  output logic                 busy,
  output logic [3:0]           rnd_q
);

  localparam int IDX_W = (NUM_DUCKS > 2) ? 2 : 1;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_DUCKS-1:0]   grant_q, grant_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic                   dir_q, dir_d;
  logic [IDX_W:0]         pick;

  lfsr4_core #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk0 (clk0),
    .rst  (rst),
    .q_o  (rnd_q)
  );

  // Returns {found, index}; the search starts just above the last winner and
  // wraps, so the slot closest after it wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_DUCKS-1:0] req,
                                             input logic [IDX_W-1:0]     last);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int off = NUM_DUCKS; off >= 1; off--) begin
      cand = (int'(last) + off) % NUM_DUCKS;
      if (req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    grant_d = '0;
    lane_d  = lane_q;
    dir_d   = dir_q;
    pick    = rr_pick(spawn_req, last_q);

    case (state_q)
      ST_IDLE: begin
        if (enable && (|spawn_req)) begin
          state_d = ST_PICK;
        end
      end

      ST_PICK: begin
        win_d   = pick[IDX_W-1:0];
        cnt_d   = 8'(DELAY_BASE) + {4'b0000, rnd_q};
        state_d = pick[IDX_W] ? ST_WAIT : ST_IDLE;
      end

      ST_WAIT: begin
        // Losing enable or the winner's request cancels without a grant.
        if (!enable || !spawn_req[win_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          lane_d  = rnd_q[LANE_W-1:0];
          dir_d   = rnd_q[3];
          grant_d = NUM_DUCKS'(1) << win_q;
          state_d = ST_ISSUE;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_ISSUE: begin
        last_d  = win_q;
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      win_q   <= '0;
      last_q  <= IDX_W'(NUM_DUCKS - 1);
      grant_q <= '0;
      lane_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      lane_q  <= lane_d;
      dir_q   <= dir_d;
    end
  end

  assign spawn_grant = grant_q;
  assign spawn_lane  = lane_q;
  assign spawn_dir   = dir_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_duck_spawn_scheduler.sv
// Self-checking bench for duck_spawn_scheduler: directed table, corner-case
// sequences and a randomized run against a behavioural model.
module tb_duck_spawn_scheduler;

  localparam int ND = 2;
  localparam int DB = 8;

  logic        clk0 = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  spawn_req = 2'b00;
  logic [1:0]  spawn_grant;
  logic [2:0]  spawn_lane;
  logic        spawn_dir;
  logic        busy;
  logic [3:0]  rnd_q;

  duck_spawn_scheduler #(
    .NUM_DUCKS  (ND),
    .DELAY_BASE (DB),
    .LFSR_SEED  (4'hF)
  ) dut (
    .clk0        (clk0),
    .rst         (rst),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .spawn_req   (spawn_req),
    .spawn_grant (spawn_grant),
    .spawn_lane  (spawn_lane),
    .spawn_dir   (spawn_dir),
    .busy        (busy),
    .rnd_q       (rnd_q)
  );

  always #5 clk0 = ~clk0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [3:0] seq_tab [15];

  typedef struct {
    int         at;
    logic [1:0] grant;
    logic [2:0] lane;
    logic       dir;
    logic       busy;
    logic [3:0] rnd;
  } vec_t;
  vec_t vt [8];

  // Model state for the randomized run
  int         m_mode;   // 0 idle, 1 pick, 2 wait, 3 issue, 4 hold
  int         m_cnt, m_win, m_last;
  logic [2:0] m_lane;
  logic       m_dir;
  logic [1:0] force_low;

  logic [1:0] g;
  logic [1:0] rr_seen [4];
  int         n_rr, drop_at [2], rel_at [2];
  int         bad, grants_rand;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; spawn_req = 2'b00; enable = 1'b0; frame_tick = 1'b0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_grant(input int budget, output logic [1:0] gr);
    gr = 2'b00;
    for (int k = 0; k < budget; k++) begin
      step();
      if (spawn_grant != 2'b00) begin
        gr = spawn_grant;
        $display("[TB] grant %b at cycle %0d lane %0d dir %0d", spawn_grant, cyc, spawn_lane, spawn_dir);
        break;
      end
    end
  endtask

  task automatic model_advance();
    logic [3:0] r;
    int s;
    r = seq_tab[cyc % 15];
    case (m_mode)
      0: if (enable && spawn_req != 2'b00) m_mode = 1;
      1: begin
        s = -1;
        for (int off = ND; off >= 1; off--)
          if (spawn_req[(m_last + off) % ND]) s = (m_last + off) % ND;
        if (s < 0) m_mode = 0;
        else begin m_win = s; m_cnt = DB + int'(r); m_mode = 2; end
      end
      2: begin
        if (!enable || !spawn_req[m_win]) m_mode = 0;
        else if (m_cnt == 0) begin m_lane = r[2:0]; m_dir = r[3]; m_mode = 3; end
        else if (frame_tick) m_cnt--;
      end
      3: begin m_last = m_win; m_mode = 4; end
      default: m_mode = 0;
    endcase
  endtask

  initial begin
    seq_tab = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
    vt[0] = '{0,  2'b00, 3'd0, 1'b0, 1'b0, 4'hF};
    vt[1] = '{1,  2'b00, 3'd0, 1'b0, 1'b1, 4'hE};
    vt[2] = '{2,  2'b00, 3'd0, 1'b0, 1'b1, 4'hC};
    vt[3] = '{24, 2'b00, 3'd0, 1'b0, 1'b1, 4'h6};
    vt[4] = '{25, 2'b01, 3'd6, 1'b0, 1'b1, 4'hD};
    vt[5] = '{26, 2'b00, 3'd6, 1'b0, 1'b1, 4'hA};
    vt[6] = '{27, 2'b00, 3'd6, 1'b0, 1'b0, 4'h5};
    vt[7] = '{40, 2'b00, 3'd6, 1'b0, 1'b0, 4'hD};

    // LFSR sequence with no requests
    do_reset();
    for (int i = 0; i <= 15; i++) begin
      check("lfsr_rnd", rnd_q, seq_tab[i % 15]);
      check("lfsr_busy", busy, 1'b0);
      if (i == 0) check("reset_grant", spawn_grant, 2'b00);
      step();
    end

    // Single spawn timing, table driven
    do_reset();
    enable = 1'b1; frame_tick = 1'b1; spawn_req = 2'b01;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      while (cyc < vt[i].at) begin
        step();
        if (cyc >= 26) spawn_req = 2'b00;
        if (cyc != 25 && spawn_grant != 2'b00) bad++;
      end
      check("single_grant", spawn_grant, vt[i].grant);
      check("single_lane", spawn_lane, vt[i].lane);
      check("single_dir", spawn_dir, vt[i].dir);
      check("single_busy", busy, vt[i].busy);
      check("single_rnd", rnd_q, vt[i].rnd);
    end
    check("single_no_stray_grant", bad, 0);

    // Round-robin with requesters dropping and re-raising after each grant
    do_reset();
    enable = 1'b1; frame_tick = 1'b1; spawn_req = 2'b11;
    n_rr = 0; drop_at = '{-1, -1}; rel_at = '{-1, -1};
    for (int k = 0; k < 600 && n_rr < 4; k++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        if (cyc == drop_at[s]) spawn_req[s] = 1'b0;
        if (cyc == rel_at[s]) spawn_req[s] = 1'b1;
      end
      if (spawn_grant != 2'b00) begin
        $display("[TB] rr grant %b at cycle %0d", spawn_grant, cyc);
        rr_seen[n_rr] = spawn_grant;
        n_rr++;
        for (int s = 0; s < 2; s++)
          if (spawn_grant[s]) begin drop_at[s] = cyc + 1; rel_at[s] = cyc + 2; end
      end
    end
    check("rr_grant_count", n_rr, 4);
    for (int k = 0; k < n_rr; k++)
      check("rr_order", rr_seen[k], (k % 2 == 0) ? 2'b01 : 2'b10);

    // Abort by dropping the request during WAIT
    do_reset();
    enable = 1'b1; frame_tick = 1'b1; spawn_req = 2'b01;
    while (cyc < 5) step();
    check("abort_busy_before", busy, 1'b1);
    spawn_req = 2'b00;
    step();
    check("abort_busy_after", busy, 1'b0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (spawn_grant != 2'b00 || busy) bad++;
    end
    check("abort_no_grant", bad, 0);

    // enable low blocks sequences; dropping enable mid-WAIT aborts
    do_reset();
    enable = 1'b0; frame_tick = 1'b1; spawn_req = 2'b11;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (spawn_grant != 2'b00 || busy) bad++;
    end
    check("enable_low_idle", bad, 0);
    enable = 1'b1;
    step(); step(); step();
    check("enable_wait_busy", busy, 1'b1);
    enable = 1'b0;
    step();
    check("enable_drop_busy", busy, 1'b0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (spawn_grant != 2'b00 || busy) bad++;
    end
    check("enable_drop_no_grant", bad, 0);

    // Reset mid-sequence after slot 0 already won
    do_reset();
    enable = 1'b1; frame_tick = 1'b1; spawn_req = 2'b01;
    wait_grant(100, g);
    check("rst_first_grant", g, 2'b01);
    spawn_req = 2'b00;
    step(); step();
    spawn_req = 2'b11;
    step(); step(); step();
    check("rst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_grant", spawn_grant, 2'b00);
    check("rst_rnd", rnd_q, 4'hF);
    rst = 1'b0;
    cyc = 0;
    wait_grant(100, g);
    check("rst_after_grant", g, 2'b01);
    check("rst_after_cycle", cyc, 25);

    // Randomized run against the behavioural model
    do_reset();
    m_mode = 0; m_cnt = 0; m_win = 0; m_last = ND - 1; m_lane = 3'd0; m_dir = 1'b0;
    force_low = 2'b00; grants_rand = 0;
    for (int k = 0; k < 4000; k++) begin
      enable = ($urandom_range(0, 99) != 0);
      frame_tick = 1'($urandom_range(0, 1));
      for (int s = 0; s < 2; s++) begin
        if (spawn_req[s] && $urandom_range(0, 63) == 0) spawn_req[s] = 1'b0;
        else if (!spawn_req[s] && $urandom_range(0, 7) == 0) spawn_req[s] = 1'b1;
      end
      spawn_req = spawn_req & ~force_low;
      force_low = (m_mode == 3) ? 2'(1 << m_win) : 2'b00;
      check("rand_busy", busy, (m_mode != 0));
      check("rand_grant", spawn_grant, (m_mode == 3) ? 2'(1 << m_win) : 2'b00);
      check("rand_lane", spawn_lane, m_lane);
      check("rand_dir", spawn_dir, m_dir);
      check("rand_rnd", rnd_q, seq_tab[cyc % 15]);
      if (spawn_grant != 2'b00) begin
        grants_rand++;
        $display("[TB] rand grant %b at cycle %0d lane %0d dir %0d", spawn_grant, cyc, spawn_lane, spawn_dir);
      end
      model_advance();
      step();
    end
    check("rand_grants_seen", (grants_rand > 0), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
